// File: rtl/data_bus_pkg.sv
// Shared types and constants for the Wishbone data-bus master: FSM states,
// RISC-V load/store size codes and fault cause codes.
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS   = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // Unsigned loads have no store form; halves need even and words need
  // 4-aligned addresses.
  function automatic logic access_ok(input logic [2:0] funct3,
                                     input logic       memrw,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !memrw;
      F3_H:    ok = !addr_lo[0];
      F3_HU:   ok = !memrw && !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Little-endian byte-lane steering: SEL/replicated store data on the way out,
// lane extraction with sign/zero extension on the way back.
module wb_lane_align
  import data_bus_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_sel,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_sel   = 4'b1111;
    st_wdata = st_data;
    case (st_funct3[1:0])
      2'b00: begin
        st_sel   = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_sel   = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_sel   = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'b0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/data_bus_master_wb.sv
// Wishbone classic single-cycle master for CPU loads/stores: legality check,
// one bus cycle per request, CPU stall via O_busy, fault reporting.
module data_bus_master_wb
  import data_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req,
  input  logic        I_memrw,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_address,
  input  logic [31:0] I_data,
  output logic [31:0] O_data,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_fault,
  output logic [1:0]  O_fault_cause,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [3:0]  SEL_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I,
  input  logic        ERR_I
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    addr_lo_q;
  logic [3:0]    st_sel;
  logic [31:0]   st_wdata;
  logic [31:0]   ld_data;

  wb_lane_align u_lane_align (
    .st_funct3  (I_funct3),
    .st_addr_lo (I_address[1:0]),
    .st_data    (I_data),
    .st_sel     (st_sel),
    .st_wdata   (st_wdata),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_rdata   (DAT_I),
    .ld_data    (ld_data)
  );

  // Bus attributes are latched at acceptance so they stay stable while STB_O is high.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      funct3_q      <= 3'b000;
      addr_lo_q     <= 2'b00;
      O_data        <= 32'h0;
      O_busy        <= 1'b0;
      O_done        <= 1'b0;
      O_fault       <= 1'b0;
      O_fault_cause <= CAUSE_NONE;
      CYC_O         <= 1'b0;
      STB_O         <= 1'b0;
      WE_O          <= 1'b0;
      ADR_O         <= 32'h0;
      SEL_O         <= 4'b0000;
      DAT_O         <= 32'h0;
    end else begin
      O_done  <= 1'b0;
      O_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (I_req) begin
            O_busy <= 1'b1;
            if (!access_ok(I_funct3, I_memrw, I_address[1:0])) begin
              state         <= FAULT;
              O_fault       <= 1'b1;
              O_fault_cause <= CAUSE_ALIGN;
            end else begin
              state     <= BUS;
              wait_cnt  <= '0;
              funct3_q  <= I_funct3;
              addr_lo_q <= I_address[1:0];
              CYC_O     <= 1'b1;
              STB_O     <= 1'b1;
              WE_O      <= I_memrw;
              ADR_O     <= {I_address[31:2], 2'b00};
              SEL_O     <= st_sel;
              DAT_O     <= st_wdata;
            end
          end
        end

        // ERR beats ACK, ACK beats the timeout on the final wait cycle.
        BUS: begin
          if (ERR_I) begin
            state         <= FAULT;
            O_fault       <= 1'b1;
            O_fault_cause <= CAUSE_BUSERR;
            CYC_O         <= 1'b0;
            STB_O         <= 1'b0;
            WE_O          <= 1'b0;
          end else if (ACK_I) begin
            state  <= DONE;
            O_done <= 1'b1;
            O_data <= WE_O ? 32'h0 : ld_data;
            CYC_O  <= 1'b0;
            STB_O  <= 1'b0;
            WE_O   <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state         <= FAULT;
            O_fault       <= 1'b1;
            O_fault_cause <= CAUSE_TIMEOUT;
            CYC_O         <= 1'b0;
            STB_O         <= 1'b0;
            WE_O          <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE, FAULT: begin
          state  <= IDLE;
          O_busy <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          O_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_master_wb.sv
// Self-checking bench for data_bus_master_wb: directed cases plus random
// accesses checked against a byte-array memory model.
module tb_data_bus_master_wb;

  localparam int TIMEOUT = 16;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic        I_req;
  logic        I_memrw;
  logic [2:0]  I_funct3;
  logic [31:0] I_address;
  logic [31:0] I_data;
  logic [31:0] O_data;
  logic        O_busy;
  logic        O_done;
  logic        O_fault;
  logic [1:0]  O_fault_cause;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [31:0] ADR_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        ACK_I;
  logic        ERR_I;

  int          check_count = 0;
  int          fail_count  = 0;
  logic [7:0]  ref_mem   [0:255];
  logic [31:0] slave_mem [0:63];
  logic [1:0]  exp_cause;

  data_bus_master_wb #(.TIMEOUT(TIMEOUT)) dut (
    .I_clk         (I_clk),
    .I_reset       (I_reset),
    .I_req         (I_req),
    .I_memrw       (I_memrw),
    .I_funct3      (I_funct3),
    .I_address     (I_address),
    .I_data        (I_data),
    .O_data        (O_data),
    .O_busy        (O_busy),
    .O_done        (O_done),
    .O_fault       (O_fault),
    .O_fault_cause (O_fault_cause),
    .CYC_O         (CYC_O),
    .STB_O         (STB_O),
    .WE_O          (WE_O),
    .ADR_O         (ADR_O),
    .SEL_O         (SEL_O),
    .DAT_O         (DAT_O),
    .DAT_I         (DAT_I),
    .ACK_I         (ACK_I),
    .ERR_I         (ERR_I)
  );

  always #5 I_clk = ~I_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int modelSize(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit modelLegal(input bit memrw, input logic [2:0] f3,
                                    input logic [31:0] addr);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (memrw && f3 >= 3'd4) return 1'b0;
    return (int'(addr[7:0]) % modelSize(f3)) == 0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
    int          size = modelSize(f3);
    int          base = int'(addr[7:0]);
    logic [31:0] v    = 32'h0;
    for (int i = 0; i < size; i++) v = v + (32'(ref_mem[base + i]) << (8 * i));
    if (f3 < 3'd4 && size < 4 && v[8 * size - 1]) v = v - (32'd1 << (8 * size));
    return v;
  endfunction

  task automatic preloadWord(input logic [31:0] addr, input logic [31:0] w);
    slave_mem[addr[7:2]] = w;
    for (int i = 0; i < 4; i++) ref_mem[int'({addr[7:2], 2'b00}) + i] = w[8 * i +: 8];
  endtask

  // One complete request: present, accept, answer after 'waits' cycles
  // (waits >= TIMEOUT means the slave stays silent), then check the outcome.
  task automatic applyStimulus(input bit memrw, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int waits, input bit err);
    int          size;
    int          k_end;
    bit          legal;
    logic [31:0] exp_sel;
    logic [31:0] exp_dat;
    legal = modelLegal(memrw, f3, addr);
    size  = modelSize(f3);
    @(negedge I_clk);
    I_req = 1'b1; I_memrw = memrw; I_funct3 = f3; I_address = addr; I_data = data;
    @(negedge I_clk);
    I_req = 1'b0; I_memrw = 1'($urandom); I_funct3 = 3'($urandom);
    I_address = $urandom; I_data = $urandom;
    checkOutput("busy after accept", O_busy, 1);
    if (!legal) begin
      exp_cause = 2'b01;
      checkOutput("align fault pulse", O_fault, 1);
      checkOutput("align fault cause", O_fault_cause, exp_cause);
      checkOutput("align no cyc", CYC_O, 0);
      checkOutput("align no done", O_done, 0);
      @(negedge I_clk);
      checkOutput("align fault one cycle", O_fault, 0);
      checkOutput("align idle busy", O_busy, 0);
      checkOutput("align still no cyc", CYC_O, 0);
      return;
    end
    exp_sel = ((32'd1 << size) - 1) << addr[1:0];
    exp_dat = (size == 1) ? 32'(data[7:0]) * 32'h0101_0101 :
              (size == 2) ? 32'(data[15:0]) * 32'h0001_0001 : data;
    checkOutput("cyc after accept", CYC_O, 1);
    checkOutput("stb after accept", STB_O, 1);
    checkOutput("we", WE_O, memrw);
    checkOutput("adr", ADR_O, addr & 32'hFFFF_FFFC);
    checkOutput("sel", SEL_O, exp_sel);
    if (memrw) checkOutput("dat_o", DAT_O, exp_dat);
    k_end = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
    for (int k = 1; k <= k_end; k++) begin
      if (k > 1) begin
        checkOutput("stb held while waiting", STB_O, 1);
        checkOutput("adr stable while waiting", ADR_O, addr & 32'hFFFF_FFFC);
      end
      if (k == waits + 1) begin
        ACK_I = 1'b1;
        if (err) begin
          ERR_I = 1'b1;
          DAT_I = $urandom;
        end else if (memrw) begin
          for (int j = 0; j < 4; j++)
            if (SEL_O[j]) slave_mem[ADR_O[7:2]][8 * j +: 8] = DAT_O[8 * j +: 8];
        end else begin
          DAT_I = slave_mem[addr[7:2]];
        end
      end else begin
        DAT_I = $urandom;
      end
      @(negedge I_clk);
    end
    ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = $urandom;
    checkOutput("cyc dropped", CYC_O, 0);
    checkOutput("stb dropped", STB_O, 0);
    if (waits >= TIMEOUT || err) begin
      exp_cause = (waits >= TIMEOUT) ? 2'b11 : 2'b10;
      checkOutput("bus fault pulse", O_fault, 1);
      checkOutput("bus fault cause", O_fault_cause, exp_cause);
      checkOutput("bus fault no done", O_done, 0);
    end else begin
      checkOutput("done pulse", O_done, 1);
      checkOutput("no fault on done", O_fault, 0);
      checkOutput("load data", O_data, memrw ? 32'h0 : modelLoad(f3, addr));
      if (memrw)
        for (int i = 0; i < size; i++) ref_mem[int'(addr[7:0]) + i] = data[8 * i +: 8];
    end
    @(negedge I_clk);
    checkOutput("done one cycle", O_done, 0);
    checkOutput("fault one cycle", O_fault, 0);
    checkOutput("busy released", O_busy, 0);
    checkOutput("cause held", O_fault_cause, exp_cause);
  endtask

  initial begin
    int          done_cnt;
    int          last_done;
    bit          rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          waits;
    int          r;
    logic [2:0]  legal_f3 [0:4];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    I_reset = 1'b1; I_req = 1'b0; I_memrw = 1'b0; I_funct3 = 3'd0;
    I_address = 32'h0; I_data = 32'h0; DAT_I = 32'h0; ACK_I = 1'b0; ERR_I = 1'b0;
    exp_cause = 2'b00;
    for (int w = 0; w < 64; w++) preloadWord(32'(w * 4), $urandom);
    repeat (2) @(negedge I_clk);
    checkOutput("reset cyc", CYC_O, 0);
    checkOutput("reset stb", STB_O, 0);
    checkOutput("reset we", WE_O, 0);
    checkOutput("reset busy", O_busy, 0);
    checkOutput("reset done", O_done, 0);
    checkOutput("reset fault", O_fault, 0);
    checkOutput("reset cause", O_fault_cause, 0);
    checkOutput("reset adr", ADR_O, 0);
    checkOutput("reset sel", SEL_O, 0);
    checkOutput("reset dat_o", DAT_O, 0);
    checkOutput("reset o_data", O_data, 0);
    I_reset = 1'b0;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
    checkOutput("lw returns stored word", O_data, 32'hDEADBEEF);
    preloadWord(32'h10, 32'h803C_5AA5);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 1, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b0);
    preloadWord(32'h10, 32'hBEEF_1234);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h06, 32'h0000_1234, 0, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h05, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 3'b100, 32'h08, 32'h55, 0, 1'b0);
    applyStimulus(1'b0, 3'b011, 32'h08, 32'h0, 0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h24, 32'h0, TIMEOUT + 4, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h24, 32'h0, TIMEOUT - 1, 1'b0);

    $display("[TB] reset during a bus cycle");
    @(negedge I_clk);
    I_req = 1'b1; I_memrw = 1'b0; I_funct3 = 3'b010; I_address = 32'h10;
    @(negedge I_clk);
    I_req = 1'b0;
    checkOutput("pre-reset cyc", CYC_O, 1);
    repeat (2) @(negedge I_clk);
    #2 I_reset = 1'b1;
    #1;
    checkOutput("async reset cyc", CYC_O, 0);
    checkOutput("async reset stb", STB_O, 0);
    checkOutput("async reset busy", O_busy, 0);
    checkOutput("async reset sel", SEL_O, 0);
    exp_cause = 2'b00;
    @(negedge I_clk);
    I_reset = 1'b0;
    @(negedge I_clk);
    ACK_I = 1'b1; DAT_I = 32'hCAFE_F00D;
    @(negedge I_clk);
    ACK_I = 1'b0;
    checkOutput("late ack no done", O_done, 0);
    checkOutput("late ack no fault", O_fault, 0);
    checkOutput("late ack idle", O_busy, 0);
    checkOutput("post reset cause", O_fault_cause, 0);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);

    $display("[TB] back-to-back loads");
    done_cnt = 0; last_done = -1;
    @(negedge I_clk);
    I_req = 1'b1; I_memrw = 1'b0; I_funct3 = 3'b010; I_address = 32'h10;
    for (int c = 0; c < 12; c++) begin
      ACK_I = CYC_O; DAT_I = slave_mem[4];
      @(negedge I_clk);
      if (O_done) begin
        checkOutput("b2b data", O_data, modelLoad(3'b010, 32'h10));
        if (last_done >= 0) checkOutput("b2b spacing", 32'(c - last_done), 3);
        last_done = c;
        done_cnt++;
      end
    end
    I_req = 1'b0; ACK_I = 1'b0;
    checkOutput("b2b done count", 32'(done_cnt), 4);
    @(negedge I_clk);
    checkOutput("b2b idle", O_busy, 0);

    $display("[TB] random accesses");
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom);
      f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0)
        addr = addr & ~(32'(modelSize(f3)) - 32'd1);
      r = $urandom_range(0, 19);
      waits = (r < 14) ? r % 4 : (r < 18) ? $urandom_range(4, TIMEOUT - 1) : TIMEOUT + 2;
      applyStimulus(rw, f3, addr, $urandom, waits, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
